unsigned_divider: RTL and testbench
===================================

# unsigned_divider

Pipelined unsigned integer divider: it computes quotient and remainder of two WIDTH-bit unsigned operands using a restoring shift-subtract algorithm, one quotient bit per pipeline stage. It accepts one division per clock and returns results in order after a fixed latency. It serves as the integer division unit behind the core's DIVU/REMU datapath.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; pipeline depth and latency equal WIDTH.

Ports:
- i_clk  input  1  single clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operand pair on i_dividend/i_divisor is sampled this edge.
- i_dividend  input  WIDTH  unsigned dividend.
- i_divisor  input  WIDTH  unsigned divisor.
- o_valid  output  1  o_quotient/o_remainder hold a completed result.
- o_quotient  output  WIDTH  floor(dividend / divisor).
- o_remainder  output  WIDTH  dividend mod divisor.

## Operation
- Restoring division, MSB first. Per stage s (0..WIDTH-1), handling dividend bit b = WIDTH-1-s:
  - partial = {rem, dividend[b]} (WIDTH+1 bits, initial rem = 0).
  - if partial >= {1'b0, divisor}: rem = partial - divisor, quotient bit b = 1; else rem = partial[WIDTH-1:0], bit = 0.
- Each stage registers: valid bit, divisor, dividend, partial quotient, partial remainder. Compare/subtract is WIDTH+1 bits wide; no truncation of the carry before comparison.
- Outputs driven directly from the final stage registers; no combinational path from inputs to outputs.
- Divide by zero (i_divisor = 0): no special case; the algorithm naturally yields o_quotient = all ones (2^WIDTH-1), o_remainder = i_dividend. No error flag.
- Divisor = 1: quotient = dividend, remainder = 0. Dividend < divisor: quotient = 0, remainder = dividend.
- Data registers of a stage load whenever the upstream stage advances (every cycle); valid bit propagates alongside. Stages carrying i_valid = 0 produce don't-care data but o_valid = 0. No backpressure: consumer must accept every o_valid pulse.
- Results leave in the same order operands entered; every operand pair is independent.

## Timing
- Latency: operands sampled on rising edge k with i_valid = 1 appear on outputs with o_valid = 1 immediately after rising edge k+WIDTH-1 (WIDTH edges counting edge k; 32 for default), held for exactly one cycle unless a following operation follows.
- Throughput: one new operation per cycle; back-to-back i_valid produces back-to-back o_valid.
- Reset: assertion immediately (asynchronously) clears every stage valid bit and all data registers; o_valid = 0, o_quotient = 0, o_remainder = 0 while i_rst is high.
- Reset mid-operation: all in-flight operations are discarded; none produce o_valid after release.
- First edge after i_rst deasserts samples inputs normally.
- i_valid = 0 cycles insert bubbles; output o_valid shows the same bubble pattern WIDTH-1 edges later.

## Test plan
- Basic vectors, one per cycle back-to-back: (0,1)->q 0 r 0; (100,10)->q 10 r 0; (100,30)->q 3 r 10; (7,15)->q 0 r 7; (0xF0F0F0F0,0xF)->q 0x10101010 r 0; (12345,1)->q 12345 r 0; each appears 32 edges after sampling, in order, consecutive o_valid.
- Divide by zero: (0x12345678,0)->q 0xFFFFFFFF r 0x12345678, o_valid asserted normally.
- Extremes: (0xFFFFFFFF,0xFFFFFFFF)->q 1 r 0; (0xFFFFFFFF,2)->q 0x7FFFFFFF r 1; (0x80000000,0x80000001)->q 0 r 0x80000000.
- Bubbles: valid pattern 1,0,1,1,0 at input -> identical o_valid pattern 31 edges later, results matching operands.
- Reset mid-flight: issue 5 ops, assert i_rst asynchronously at cycle 10 -> outputs and o_valid go 0 immediately; after release no stale o_valid ever appears; new op after release completes with correct latency.
- Random: 10k random operand pairs (including divisor 0 and 1 bias) streamed every cycle -> each result equals reference q/r; q*divisor+r == dividend and r < divisor when divisor != 0.

Source files
------------

// File: rtl/unsigned_divider.sv
// -----------------------------------------------------------------------------
// unsigned_divider
//
// Pipelined restoring divider for WIDTH-bit unsigned operands. Each pipeline
// stage resolves one quotient bit, MSB first. A new operand pair can be
// accepted every clock. Results leave in issue order, WIDTH edges after the
// operands are sampled (the sampling edge counts as the first edge).
//
// Divide by zero is not special-cased. The algorithm itself produces
// quotient = all ones and remainder = dividend in that case.
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_rst        asynchronous, active-high reset; clears every stage
//   i_valid      i_dividend/i_divisor are sampled on this edge
//   i_dividend   unsigned dividend
//   i_divisor    unsigned divisor
//   o_valid      o_quotient/o_remainder hold a completed result
//   o_quotient   floor(dividend / divisor)
//   o_remainder  dividend mod divisor
// -----------------------------------------------------------------------------
module unsigned_divider #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   // Stage registers. Index s holds the state after quotient bit WIDTH-1-s
   // has been resolved.
   logic             vld_p [WIDTH];
   logic [WIDTH-1:0] dvd_p [WIDTH];
   logic [WIDTH-1:0] dvs_p [WIDTH];
   logic [WIDTH-1:0] quo_p [WIDTH];
   logic [WIDTH-1:0] rem_p [WIDTH];

   // Per-stage inputs. Stage 0 is fed from the ports; every later stage is
   // fed from the register of the stage before it.
   logic             vld_in [WIDTH];
   logic [WIDTH-1:0] dvd_in [WIDTH];
   logic [WIDTH-1:0] dvs_in [WIDTH];
   logic [WIDTH-1:0] quo_in [WIDTH];
   logic [WIDTH-1:0] rem_in [WIDTH];

   logic [WIDTH:0]   step_res [WIDTH];
   logic [WIDTH-1:0] quo_nxt  [WIDTH];
   logic [WIDTH-1:0] rem_nxt  [WIDTH];

   // One restoring step. The result is {quotient_bit, new_remainder}.
   // The comparison uses WIDTH+1 bits, so the bit shifted out of the
   // remainder still counts. Subtracting in WIDTH bits gives the right
   // value whenever partial >= divisor. With a zero divisor it simply keeps
   // the shifted partial, which makes the remainder equal the dividend.
   function automatic logic [WIDTH:0] restore_step(
      input logic [WIDTH-1:0] rem,
      input logic             dvd_bit,
      input logic [WIDTH-1:0] divisor
   );
      logic [WIDTH:0] partial;
      partial = {rem, dvd_bit};
      if (partial >= {1'b0, divisor})
         restore_step = {1'b1, partial[WIDTH-1:0] - divisor};
      else
         restore_step = {1'b0, partial[WIDTH-1:0]};
   endfunction

   always_comb begin
      vld_in[0] = i_valid;
      dvd_in[0] = i_dividend;
      dvs_in[0] = i_divisor;
      quo_in[0] = '0;
      rem_in[0] = '0;
      for (int s = 1; s < WIDTH; s++) begin
         vld_in[s] = vld_p[s-1];
         dvd_in[s] = dvd_p[s-1];
         dvs_in[s] = dvs_p[s-1];
         quo_in[s] = quo_p[s-1];
         rem_in[s] = rem_p[s-1];
      end
      for (int s = 0; s < WIDTH; s++) begin
         step_res[s] = restore_step(rem_in[s], dvd_in[s][WIDTH-1-s], dvs_in[s]);
         rem_nxt[s]  = step_res[s][WIDTH-1:0];
         quo_nxt[s]  = quo_in[s];
         quo_nxt[s][WIDTH-1-s] = step_res[s][WIDTH];
      end
   end

   // ---- stage boundary: every stage register loads each cycle ----
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int s = 0; s < WIDTH; s++) begin
            vld_p[s] <= 1'b0;
            dvd_p[s] <= '0;
            dvs_p[s] <= '0;
            quo_p[s] <= '0;
            rem_p[s] <= '0;
         end
      end else begin
         for (int s = 0; s < WIDTH; s++) begin
            vld_p[s] <= vld_in[s];
            dvd_p[s] <= dvd_in[s];
            dvs_p[s] <= dvs_in[s];
            quo_p[s] <= quo_nxt[s];
            rem_p[s] <= rem_nxt[s];
         end
      end
   end

   // ---- output boundary: straight from the last stage registers ----
   assign o_valid     = vld_p[WIDTH-1];
   assign o_quotient  = quo_p[WIDTH-1];
   assign o_remainder = rem_p[WIDTH-1];

endmodule

// File: tb/tb_unsigned_divider.sv
module tb_unsigned_divider;

   localparam int WIDTH = 32;
   localparam int LAT   = 32;  // negedge-to-negedge distance from drive to result

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_valid;
   logic [WIDTH-1:0] i_dividend;
   logic [WIDTH-1:0] i_divisor;
   logic             o_valid;
   logic [WIDTH-1:0] o_quotient;
   logic [WIDTH-1:0] o_remainder;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [WIDTH-1:0] exp_q [$];
   logic [WIDTH-1:0] exp_r [$];
   int               exp_c [$];
   logic [WIDTH-1:0] in_a  [$];
   logic [WIDTH-1:0] in_b  [$];
   logic [WIDTH-1:0] act_q [$];
   logic [WIDTH-1:0] act_r [$];
   int               act_c [$];

   unsigned_divider #(.WIDTH(WIDTH)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .i_dividend  (i_dividend),
      .i_divisor   (i_divisor),
      .o_valid     (o_valid),
      .o_quotient  (o_quotient),
      .o_remainder (o_remainder)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Record every result the DUT presents, with the edge count it appeared at.
   always @(negedge i_clk) begin
      if (o_valid === 1'b1) begin
         act_q.push_back(o_quotient);
         act_r.push_back(o_remainder);
         act_c.push_back(cyc);
      end
   end

   task automatic clear_queues();
      exp_q.delete(); exp_r.delete(); exp_c.delete();
      in_a.delete();  in_b.delete();
      act_q.delete(); act_r.delete(); act_c.delete();
   endtask

   // Drive one operand pair (called just after a negedge) with its expected result.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
      i_valid    = 1'b1;
      i_dividend = a;
      i_divisor  = b;
      exp_q.push_back(q);
      exp_r.push_back(r);
      exp_c.push_back(cyc + LAT);
      in_a.push_back(a);
      in_b.push_back(b);
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) @(negedge i_clk);
   endtask

   // Bounded wait for all expected results, plus a margin to catch extras.
   task automatic drain(input int budget);
      int n;
      n = 0;
      while (act_q.size() < exp_q.size() && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      repeat (4) @(negedge i_clk);
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 1'b0; i_dividend = '0; i_divisor = '0;
      repeat (3) @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
      checks++;
      if (o_quotient !== '0) begin failures++; $display("FAIL reset_quotient got=%h want=0", o_quotient); end
      checks++;
      if (o_remainder !== '0) begin failures++; $display("FAIL reset_remainder got=%h want=0", o_remainder); end
      i_rst = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic test_basic();
      clear_queues();
      issue(32'd0,          32'd1,   32'd0,          32'd0);
      issue(32'd100,        32'd10,  32'd10,         32'd0);
      issue(32'd100,        32'd30,  32'd3,          32'd10);
      issue(32'd7,          32'd15,  32'd0,          32'd7);
      issue(32'hF0F0F0F0,   32'hF,   32'h10101010,   32'd0);
      issue(32'd12345,      32'd1,   32'd12345,      32'd0);
      drain(100);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= act_q.size()) begin
            failures++; $display("FAIL basic[%0d] no result, want q=%h r=%h", i, exp_q[i], exp_r[i]);
         end else if (act_q[i] !== exp_q[i] || act_r[i] !== exp_r[i] || act_c[i] !== exp_c[i]) begin
            failures++;
            $display("FAIL basic[%0d] got q=%h r=%h cyc=%0d want q=%h r=%h cyc=%0d",
                     i, act_q[i], act_r[i], act_c[i], exp_q[i], exp_r[i], exp_c[i]);
         end
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
         failures++; $display("FAIL basic_count got=%0d want=%0d", act_q.size(), exp_q.size());
      end
   endtask

   task automatic test_div_zero_and_extremes();
      clear_queues();
      issue(32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h0);
      issue(32'hFFFFFFFF, 32'h2,        32'h7FFFFFFF, 32'h1);
      issue(32'h80000000, 32'h80000001, 32'h0,        32'h80000000);
      issue(32'h0,        32'h0,        32'hFFFFFFFF, 32'h0);
      drain(100);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= act_q.size()) begin
            failures++; $display("FAIL extreme[%0d] no result, want q=%h r=%h", i, exp_q[i], exp_r[i]);
         end else if (act_q[i] !== exp_q[i] || act_r[i] !== exp_r[i] || act_c[i] !== exp_c[i]) begin
            failures++;
            $display("FAIL extreme[%0d] got q=%h r=%h cyc=%0d want q=%h r=%h cyc=%0d",
                     i, act_q[i], act_r[i], act_c[i], exp_q[i], exp_r[i], exp_c[i]);
         end
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
         failures++; $display("FAIL extreme_count got=%0d want=%0d", act_q.size(), exp_q.size());
      end
   endtask

   // Input valid pattern 1,0,1,1,0: exact output cycles must show the same gaps.
   task automatic test_bubbles();
      clear_queues();
      issue(32'd1000, 32'd7, 32'd142, 32'd6);
      idle(1);
      issue(32'd55,   32'd5, 32'd11,  32'd0);
      issue(32'd9,    32'd4, 32'd2,   32'd1);
      idle(1);
      drain(100);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= act_q.size()) begin
            failures++; $display("FAIL bubble[%0d] no result, want q=%h r=%h", i, exp_q[i], exp_r[i]);
         end else if (act_q[i] !== exp_q[i] || act_r[i] !== exp_r[i] || act_c[i] !== exp_c[i]) begin
            failures++;
            $display("FAIL bubble[%0d] got q=%h r=%h cyc=%0d want q=%h r=%h cyc=%0d",
                     i, act_q[i], act_r[i], act_c[i], exp_q[i], exp_r[i], exp_c[i]);
         end
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
         failures++; $display("FAIL bubble_count got=%0d want=%0d", act_q.size(), exp_q.size());
      end
   endtask

   task automatic test_reset_midflight();
      clear_queues();
      for (int i = 0; i < 5; i++) begin
         i_valid = 1'b1; i_dividend = 32'hDEAD0000 + i; i_divisor = 32'd3 + i;
         @(negedge i_clk);
      end
      idle(5);
      // Assert reset between edges to show it acts without a clock edge.
      @(posedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", o_valid); end
      checks++;
      if (o_quotient !== '0) begin failures++; $display("FAIL midrst_quotient got=%h want=0", o_quotient); end
      checks++;
      if (o_remainder !== '0) begin failures++; $display("FAIL midrst_remainder got=%h want=0", o_remainder); end
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      idle(40);
      checks++;
      if (act_q.size() != 0) begin
         failures++; $display("FAIL midrst_stale got=%0d results want=0", act_q.size());
      end
      clear_queues();
      issue(32'd100, 32'd30, 32'd3, 32'd10);
      drain(100);
      checks++;
      if (act_q.size() != 1) begin
         failures++; $display("FAIL midrst_new_count got=%0d want=1", act_q.size());
      end else if (act_q[0] !== exp_q[0] || act_r[0] !== exp_r[0] || act_c[0] !== exp_c[0]) begin
         failures++;
         $display("FAIL midrst_new got q=%h r=%h cyc=%0d want q=%h r=%h cyc=%0d",
                  act_q[0], act_r[0], act_c[0], exp_q[0], exp_r[0], exp_c[0]);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b, q, r;
      logic [2*WIDTH-1:0] recon;
      int sel;
      int bad;
      clear_queues();
      for (int i = 0; i < 10000; i++) begin
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: b = '0;
            1: b = 32'd1;
            2: b = $urandom_range(2, 255);
            3: a = $urandom_range(0, 1000);
            default: ;
         endcase
         q = (b == 0) ? '1 : a / b;
         r = (b == 0) ? a  : a % b;
         issue(a, b, q, r);
      end
      drain(200);
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= act_q.size()) begin
            failures++; bad++;
            if (bad < 10) $display("FAIL random[%0d] no result", i);
         end else begin
            if (act_q[i] !== exp_q[i] || act_r[i] !== exp_r[i] || act_c[i] !== exp_c[i]) begin
               failures++; bad++;
               if (bad < 10)
                  $display("FAIL random[%0d] a=%h b=%h got q=%h r=%h cyc=%0d want q=%h r=%h cyc=%0d",
                           i, in_a[i], in_b[i], act_q[i], act_r[i], act_c[i], exp_q[i], exp_r[i], exp_c[i]);
            end
            if (in_b[i] != 0) begin
               checks++;
               recon = {{WIDTH{1'b0}}, act_q[i]} * {{WIDTH{1'b0}}, in_b[i]} + {{WIDTH{1'b0}}, act_r[i]};
               if (recon !== {{WIDTH{1'b0}}, in_a[i]} || act_r[i] >= in_b[i]) begin
                  failures++; bad++;
                  if (bad < 10)
                     $display("FAIL random_identity[%0d] q*b+r=%h r=%h want a=%h with r<b=%h",
                              i, recon, act_r[i], in_a[i], in_b[i]);
               end
            end
         end
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
         failures++; $display("FAIL random_count got=%0d want=%0d", act_q.size(), exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero_and_extremes();
      test_bubbles();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
